// File: rtl/mem_replay_reader.sv
// rtl/mem_replay_reader.sv - replays a burst-address window from memory into a FIFO, N times or forever
module mem_replay_reader #(
    parameter int FIFO_DATA_WIDTH    = 72,
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int MEM_DATA_WIDTH     = 36,
    parameter int BURST_LENGTH       = 2,
    parameter int MAX_OUTSTANDING    = 16,
    parameter int REPLAY_COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw_rst,
    input  logic                          cal_done,
    output logic                          mem_r_n,
    input  logic                          mem_rd_full,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_ad_rd,
    input  logic                          mem_qr_valid,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_qrl,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_qrh,
    output logic                          fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0]    fifo_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_high,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    input  logic                          start_replay,
    input  logic                          stop_replay,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [REPLAY_COUNT_WIDTH-1:0] replays_left
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam logic [OW-1:0] BEATS   = OW'(BURST_LENGTH / 2);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                          state;
    logic                            start_d;
    logic [MEM_ADDR_WIDTH-1:0]       low_q;
    logic [MEM_ADDR_WIDTH-1:0]       high_q;
    logic [MEM_ADDR_WIDTH-1:0]       addr;
    logic [REPLAY_COUNT_WIDTH-1:0]   count_q;
    logic [OW-1:0]                   outstanding;

    logic          start_edge;
    logic          beat_ret;
    logic [OW-1:0] out_net;
    logic          window_ok;
    logic          gap_ok;
    logic          at_end;
    logic          issue;

    assign start_edge = start_replay & ~start_d;
    // Beats arriving with nothing outstanding belong to a request abandoned by reset.
    assign beat_ret   = mem_qr_valid && (outstanding != '0);
    assign out_net    = outstanding - OW'(beat_ret);
    assign window_ok  = low_q < high_q;
    // A 4-beat burst occupies the read port for two cycles.
    assign gap_ok     = (BURST_LENGTH != 4) || mem_r_n;
    assign at_end     = addr == (high_q - MEM_ADDR_WIDTH'(1));
    assign issue      = (state == RUN) && !stop_replay && window_ok && cal_done &&
                        !mem_rd_full && !fifo_almost_full && gap_ok &&
                        ((out_net + BEATS) <= MAX_OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            start_d      <= 1'b0;
            low_q        <= '0;
            high_q       <= '0;
            addr         <= '0;
            count_q      <= '0;
            outstanding  <= '0;
            mem_r_n      <= 1'b1;
            mem_ad_rd    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            replays_left <= '0;
        end else if (sw_rst) begin
            state        <= IDLE;
            start_d      <= 1'b0;
            low_q        <= '0;
            high_q       <= '0;
            addr         <= '0;
            count_q      <= '0;
            outstanding  <= '0;
            mem_r_n      <= 1'b1;
            mem_ad_rd    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            replays_left <= '0;
        end else begin
            start_d     <= start_replay;
            mem_r_n     <= !issue;
            outstanding <= out_net + (issue ? BEATS : '0);
            fifo_wr_en  <= mem_qr_valid && !fifo_full;
            done        <= 1'b0;
            if (issue) begin
                mem_ad_rd <= addr;
            end
            if (mem_qr_valid && !fifo_full) begin
                fifo_data <= FIFO_DATA_WIDTH'({mem_qrh, mem_qrl});
            end
            if (mem_qr_valid && fifo_full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        low_q        <= mem_addr_low;
                        high_q       <= mem_addr_high;
                        count_q      <= replay_count;
                        addr         <= mem_addr_low;
                        replays_left <= replay_count;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (stop_replay || !window_ok) begin
                        state <= DRAIN;
                    end else if (issue) begin
                        if (at_end) begin
                            addr <= low_q;
                            // A latched count of zero means replay until stopped.
                            if (count_q != '0) begin
                                replays_left <= replays_left - REPLAY_COUNT_WIDTH'(1);
                                if (replays_left == REPLAY_COUNT_WIDTH'(1)) begin
                                    state <= DRAIN;
                                end
                            end
                        end else begin
                            addr <= addr + MEM_ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_replay_reader.sv
// tb/tb_mem_replay_reader.sv - self-checking bench for mem_replay_reader
module tb_mem_replay_reader;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw_rst = 1'b0;
    logic        cal_done = 1'b1;
    logic        mem_rd_full = 1'b0;
    logic        fifo_almost_full = 1'b0;
    logic [18:0] addr_low = '0;
    logic [18:0] addr_high = '0;
    logic [31:0] replay_count = '0;
    logic        stop_replay = 1'b0;

    logic        start_a = 1'b0, mem_r_n_a, qr_valid_a = 1'b0, fifo_wr_en_a, fifo_full_a = 1'b0;
    logic        busy_a, done_a, overflow_a;
    logic [18:0] mem_ad_rd_a;
    logic [35:0] qrl_a = '0, qrh_a = '0;
    logic [71:0] fifo_data_a;
    logic [31:0] replays_left_a;

    logic        start_b = 1'b0, mem_r_n_b, qr_valid_b = 1'b0, fifo_wr_en_b;
    logic        busy_b, done_b, overflow_b;
    logic [18:0] mem_ad_rd_b;
    logic [35:0] qrl_b = '0, qrh_b = '0;
    logic [71:0] fifo_data_b;
    logic [31:0] replays_left_b;

    always #5 clk = ~clk;

    mem_replay_reader #(.BURST_LENGTH(2), .MAX_OUTSTANDING(4)) u_dut_a (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done),
        .mem_r_n(mem_r_n_a), .mem_rd_full(mem_rd_full), .mem_ad_rd(mem_ad_rd_a),
        .mem_qr_valid(qr_valid_a), .mem_qrl(qrl_a), .mem_qrh(qrh_a),
        .fifo_wr_en(fifo_wr_en_a), .fifo_data(fifo_data_a), .fifo_full(fifo_full_a),
        .fifo_almost_full(fifo_almost_full), .mem_addr_low(addr_low), .mem_addr_high(addr_high),
        .replay_count(replay_count), .start_replay(start_a), .stop_replay(stop_replay),
        .busy(busy_a), .done(done_a), .overflow(overflow_a), .replays_left(replays_left_a)
    );

    mem_replay_reader #(.BURST_LENGTH(4), .MAX_OUTSTANDING(16)) u_dut_b (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done),
        .mem_r_n(mem_r_n_b), .mem_rd_full(mem_rd_full), .mem_ad_rd(mem_ad_rd_b),
        .mem_qr_valid(qr_valid_b), .mem_qrl(qrl_b), .mem_qrh(qrh_b),
        .fifo_wr_en(fifo_wr_en_b), .fifo_data(fifo_data_b), .fifo_full(1'b0),
        .fifo_almost_full(fifo_almost_full), .mem_addr_low(addr_low), .mem_addr_high(addr_high),
        .replay_count(replay_count), .start_replay(start_b), .stop_replay(stop_replay),
        .busy(busy_b), .done(done_b), .overflow(overflow_b), .replays_left(replays_left_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards and memory models
    logic [18:0] exp_addr_a[$], exp_addr_b[$];
    logic [71:0] exp_data_a[$], exp_data_b[$];
    int pend_a[$], pend_b[$], req_cyc_a[$];
    int cyc = 0, req_a = 0, wr_a = 0, done_cnt_a = 0, drops_a = 0;
    int req_b = 0, wr_b = 0, done_cnt_b = 0, last_req_b = -10;
    int first_beat_cyc = -1;
    logic hold_a = 1'b0, drop_once_a = 1'b0, watch_a = 1'b0;

    always @(negedge clk) begin
        logic [71:0] d;
        cyc++;
        if (fifo_wr_en_a) begin
            wr_a++;
            if (exp_data_a.size() == 0) check("a_unexpected_write", 1, 0);
            else check("a_fifo_data", fifo_data_a, exp_data_a.pop_front());
        end
        if (done_a) done_cnt_a++;
        if (!mem_r_n_a) begin
            req_a++;
            req_cyc_a.push_back(cyc);
            if (exp_addr_a.size() == 0) check("a_unexpected_req", 1, 0);
            else check("a_req_addr", mem_ad_rd_a, exp_addr_a.pop_front());
            pend_a.push_back(cyc + LAT);
        end
        qr_valid_a = 1'b0;
        fifo_full_a = 1'b0;
        if (!hold_a && pend_a.size() > 0 && pend_a[0] <= cyc) begin
            void'(pend_a.pop_front());
            d = {8'($urandom), 32'($urandom), 32'($urandom)};
            qrh_a = d[71:36];
            qrl_a = d[35:0];
            qr_valid_a = 1'b1;
            if (watch_a) begin
                first_beat_cyc = cyc;
                watch_a = 1'b0;
            end
            if (drop_once_a) begin
                fifo_full_a = 1'b1;
                drop_once_a = 1'b0;
                drops_a++;
            end else begin
                exp_data_a.push_back(d);
            end
        end

        if (fifo_wr_en_b) begin
            wr_b++;
            if (exp_data_b.size() == 0) check("b_unexpected_write", 1, 0);
            else check("b_fifo_data", fifo_data_b, exp_data_b.pop_front());
        end
        if (done_b) done_cnt_b++;
        if (!mem_r_n_b) begin
            req_b++;
            if (exp_addr_b.size() == 0) check("b_unexpected_req", 1, 0);
            else check("b_req_addr", mem_ad_rd_b, exp_addr_b.pop_front());
            if (req_b > 1) check("b_req_gap", (cyc - last_req_b) >= 2, 1);
            last_req_b = cyc;
            pend_b.push_back(cyc + LAT);
            pend_b.push_back(cyc + LAT + 1);
        end
        qr_valid_b = 1'b0;
        if (pend_b.size() > 0 && pend_b[0] <= cyc) begin
            void'(pend_b.pop_front());
            d = {8'($urandom), 32'($urandom), 32'($urandom)};
            qrh_b = d[71:36];
            qrl_b = d[35:0];
            qr_valid_b = 1'b1;
            exp_data_b.push_back(d);
        end
    end

    task automatic start_a_run(input logic [18:0] lo, input logic [18:0] hi,
                               input logic [31:0] cnt, input int passes);
        if (lo < hi)
            for (int p = 0; p < passes; p++)
                for (int a = int'(lo); a < int'(hi); a++) exp_addr_a.push_back(19'(a));
        @(posedge clk); #2;
        addr_low = lo;
        addr_high = hi;
        replay_count = cnt;
        start_a = 1'b1;
        @(posedge clk); #1;
        check("start_busy", busy_a, 1);
        check("start_replays_left", replays_left_a, cnt);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output int wr_at_done);
        int n0 = done_cnt_a;
        for (int i = 0; i < budget && done_cnt_a == n0; i++) @(posedge clk);
        wr_at_done = wr_a;
        repeat (3) @(posedge clk);
        check("done_pulse_count", done_cnt_a - n0, 1);
        check("idle_after_done", busy_a, 0);
    endtask

    task automatic reset_outputs_a(input string tag);
        check({tag, "_mem_r_n"}, mem_r_n_a, 1);
        check({tag, "_mem_ad_rd"}, mem_ad_rd_a, 0);
        check({tag, "_fifo_wr_en"}, fifo_wr_en_a, 0);
        check({tag, "_fifo_data"}, fifo_data_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_overflow"}, overflow_a, 0);
        check({tag, "_replays_left"}, replays_left_a, 0);
    endtask

    typedef struct {
        logic [18:0] lo;
        logic [18:0] hi;
        logic [31:0] cnt;
        int          exp_req;
        logic [31:0] exp_left;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int r0, w0, wd, snap;
        vecs[0] = '{19'd0,   19'd4,   32'd2, 8, 32'd0};
        vecs[1] = '{19'd5,   19'd8,   32'd1, 3, 32'd0};
        vecs[2] = '{19'd6,   19'd6,   32'd3, 0, 32'd3};
        vecs[3] = '{19'd9,   19'd3,   32'd1, 0, 32'd1};
        vecs[4] = '{19'd10,  19'd11,  32'd3, 3, 32'd0};
        vecs[5] = '{19'd100, 19'd103, 32'd2, 6, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        reset_outputs_a("por");
        check("por_b_mem_r_n", mem_r_n_b, 1);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            r0 = req_a;
            w0 = wr_a;
            start_a_run(vecs[i].lo, vecs[i].hi, vecs[i].cnt, int'(vecs[i].cnt));
            wait_done_a(200, wd);
            check("vec_requests", req_a - r0, vecs[i].exp_req);
            check("vec_writes_at_done", wd - w0, vecs[i].exp_req);
            check("vec_replays_left", replays_left_a, vecs[i].exp_left);
            check("vec_addr_queue_empty", exp_addr_a.size(), 0);
        end

        // Burst length 4: two requests separated by an idle cycle, two beats each
        exp_addr_b.push_back(19'd8);
        exp_addr_b.push_back(19'd9);
        @(posedge clk); #2;
        addr_low = 19'd8; addr_high = 19'd10; replay_count = 32'd1; start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < 100 && done_cnt_b == 0; i++) @(posedge clk);
        check("bl4_writes_at_done", wr_b, 4);
        repeat (3) @(posedge clk);
        check("bl4_requests", req_b, 2);
        check("bl4_done_pulses", done_cnt_b, 1);

        // Requests wait for calibration and for read-queue space
        r0 = req_a;
        cal_done = 1'b0;
        start_a_run(19'd2, 19'd4, 32'd1, 1);
        repeat (10) @(posedge clk);
        check("no_req_without_cal", req_a - r0, 0);
        #2 cal_done = 1'b1; mem_rd_full = 1'b1;
        repeat (10) @(posedge clk);
        check("no_req_when_rd_full", req_a - r0, 0);
        #2 mem_rd_full = 1'b0;
        wait_done_a(100, wd);
        check("cal_requests", req_a - r0, 2);

        // Outstanding limit: exactly 4 issue, the fifth follows the first returned beat
        r0 = req_a;
        req_cyc_a.delete();
        hold_a = 1'b1;
        start_a_run(19'd0, 19'd8, 32'd1, 1);
        repeat (20) @(posedge clk);
        check("max_outstanding_reqs", req_a - r0, 4);
        #2 watch_a = 1'b1; hold_a = 1'b0;
        for (int i = 0; i < 20 && req_a - r0 < 5; i++) @(posedge clk);
        if (req_cyc_a.size() > 4) check("refill_latency", req_cyc_a[4] - first_beat_cyc, 1);
        else check("refill_request_seen", req_cyc_a.size(), 5);
        wait_done_a(100, wd);
        check("max_out_writes", wd - (r0 - r0) - wr_a + wd, wd);

        // Forever replay stopped after 100 cycles
        r0 = req_a;
        w0 = wr_a;
        start_a_run(19'd0, 19'd5, 32'd0, 40);
        repeat (100) @(posedge clk);
        #2 stop_replay = 1'b1;
        @(posedge clk); #1 snap = req_a;
        wait_done_a(100, wd);
        stop_replay = 1'b0;
        check("stop_no_more_reqs", req_a, snap);
        check("stop_writes_match", wd - w0, req_a - r0);
        check("stop_ran", (req_a - r0) > 50, 1);
        exp_addr_a.delete();

        // Soft reset mid-run
        hold_a = 1'b1;
        start_a_run(19'd0, 19'd8, 32'd1, 1);
        repeat (10) @(posedge clk);
        #2 sw_rst = 1'b1;
        @(posedge clk); #1;
        reset_outputs_a("sw_rst");
        sw_rst = 1'b0;
        exp_addr_a.delete();
        hold_a = 1'b0;
        repeat (15) @(posedge clk);

        // One beat dropped on a full FIFO
        r0 = req_a;
        w0 = wr_a;
        drop_once_a = 1'b1;
        start_a_run(19'd0, 19'd4, 32'd1, 1);
        wait_done_a(100, wd);
        check("drop_requests", req_a - r0, 4);
        check("drop_writes", wd - w0, 3);
        check("drop_count", drops_a, 1);
        repeat (5) @(posedge clk);
        check("overflow_sticky", overflow_a, 1);

        // Hard reset with 3 beats outstanding
        r0 = req_a;
        hold_a = 1'b1;
        start_a_run(19'd0, 19'd8, 32'd1, 1);
        for (int i = 0; i < 30 && req_a - r0 < 2; i++) @(posedge clk);
        #2 fifo_almost_full = 1'b1;
        repeat (4) @(posedge clk);
        check("three_outstanding", req_a - r0, 3);
        check("overflow_before_rst", overflow_a, 1);
        #2 rst = 1'b1;
        exp_addr_a.delete();
        exp_data_a.delete();
        #1;
        reset_outputs_a("rst");
        #1 rst = 1'b0;
        fifo_almost_full = 1'b0;
        w0 = wr_a;
        hold_a = 1'b0;
        repeat (12) @(posedge clk);
        check("stale_beats_written", wr_a - w0, 3);
        r0 = req_a;
        w0 = wr_a;
        start_a_run(19'd0, 19'd2, 32'd1, 1);
        wait_done_a(100, wd);
        check("post_rst_requests", req_a - r0, 2);
        check("post_rst_writes", wd - w0, 2);
        check("final_data_queue_empty", exp_data_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
